// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single SRAM controller.
// Requester 0 is instruction fetch and requester 1 is the MEM stage.
// Only one transaction is in flight at a time.
// Simultaneous requests are resolved round-robin.
// A read wins when a requester raises read and write together.
module mem_arbiter #(
    parameter int ADDRESS_LEN = 32,
    parameter int DATA_LEN    = 32,
    parameter int READ_LEN    = 64
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_read_en,
    input  logic                   m0_write_en,
    input  logic [ADDRESS_LEN-1:0] m0_address,
    input  logic [DATA_LEN-1:0]    m0_write_data,
    output logic [READ_LEN-1:0]    m0_read_data,
    output logic                   m0_ready,

    input  logic                   m1_read_en,
    input  logic                   m1_write_en,
    input  logic [ADDRESS_LEN-1:0] m1_address,
    input  logic [DATA_LEN-1:0]    m1_write_data,
    output logic [READ_LEN-1:0]    m1_read_data,
    output logic                   m1_ready,

    output logic                   sram_read_en,
    output logic                   sram_write_en,
    output logic [ADDRESS_LEN-1:0] sram_address,
    output logic [DATA_LEN-1:0]    sram_write_data,
    input  logic [READ_LEN-1:0]    sram_read_data,
    input  logic                   sram_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
    logic                   grant_q, grant_d;
    logic                   cmd_rd_q, cmd_rd_d;
    logic                   cmd_wr_q, cmd_wr_d;
    logic [ADDRESS_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0]    wdata_q, wdata_d;
    logic                   seen_busy_q, seen_busy_d;
    logic [READ_LEN-1:0]    m0_rdata_q, m0_rdata_d;
    logic [READ_LEN-1:0]    m1_rdata_q, m1_rdata_d;

    logic req0, req1;
    logic pick;

    assign req0 = m0_read_en | m0_write_en;
    assign req1 = m1_read_en | m1_write_en;

    // Register file for FSM state, latched command and returned read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;  // lets m0 win the first tie after reset
            grant_q      <= 1'b0;
            cmd_rd_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            seen_busy_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_wr_q     <= cmd_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            seen_busy_q  <= seen_busy_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, then issue, wait and complete
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cmd_rd_d     = cmd_rd_q;
        cmd_wr_d     = cmd_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        seen_busy_d  = seen_busy_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        pick         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // m0 wins when it asks alone, or on a tie when m1 went last
                    pick         = !(req0 && (!req1 || last_grant_q));
                    grant_d      = pick;
                    last_grant_d = pick;
                    if (pick) begin
                        cmd_rd_d = m1_read_en;
                        cmd_wr_d = m1_write_en & ~m1_read_en;
                        addr_d   = m1_address;
                        wdata_d  = m1_write_data;
                    end else begin
                        cmd_rd_d = m0_read_en;
                        cmd_wr_d = m0_write_en & ~m0_read_en;
                        addr_d   = m0_address;
                        wdata_d  = m0_write_data;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                seen_busy_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                // A ready seen before the controller has gone busy is stale
                if (!sram_ready) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (cmd_rd_q) begin
                        if (grant_q) m1_rdata_d = sram_read_data;
                        else         m0_rdata_d = sram_read_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready outputs: granted side follows the FSM, the other side mirrors its own request
    always_comb begin
        m0_ready = ~req0;
        m1_ready = ~req1;
        if (state_q == ISSUE || state_q == WAIT) begin
            if (grant_q) m1_ready = 1'b0;
            else         m0_ready = 1'b0;
        end else if (state_q == DONE) begin
            if (grant_q) m1_ready = 1'b1;
            else         m0_ready = 1'b1;
        end
        if (!rst) begin
            m0_ready = 1'b1;
            m1_ready = 1'b1;
        end
    end

    assign sram_read_en    = (state_q == ISSUE) && cmd_rd_q;
    assign sram_write_en   = (state_q == ISSUE) && cmd_wr_q;
    assign sram_address    = addr_q;
    assign sram_write_data = wdata_q;
    assign m0_read_data    = m0_rdata_q;
    assign m1_read_data    = m1_rdata_q;

endmodule
